// File: rtl/snn_pe_pkg.sv
// Shared types and packet packing helper for the spike-row convolution PE.
package snn_pe_pkg;

   typedef enum logic [1:0] {
      S_NOFILT   = 2'd0,
      S_WAIT_ROW = 2'd1,
      S_COMPUTE  = 2'd2
   } state_t;

   localparam int unsigned PKT_MAX = 128;

   // Field LSB offsets inside a packet of width packet_w (row/col/ch packed from the MSB down).
   function automatic int unsigned row_lsb(input int unsigned packet_w, input int unsigned addr_w);
      return packet_w - addr_w;
   endfunction

   function automatic int unsigned col_lsb(input int unsigned packet_w, input int unsigned addr_w);
      return packet_w - 2 * addr_w;
   endfunction

   function automatic int unsigned ch_lsb(input int unsigned packet_w, input int unsigned addr_w,
                                          input int unsigned ch_w);
      return packet_w - 2 * addr_w - ch_w;
   endfunction

   function automatic logic [31:0] field_mask(input int unsigned w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return 32'(m);
   endfunction

   // Pad bits between ch and psum stay zero because every field is masked to its width.
   function automatic logic [PKT_MAX-1:0] pack_psum(
      input logic [31:0] row, input logic [31:0] col, input logic [31:0] ch, input logic [31:0] psum,
      input int unsigned packet_w, input int unsigned addr_w, input int unsigned ch_w,
      input int unsigned psum_w);
      logic [PKT_MAX-1:0] p;
      p = '0;
      p = p | (PKT_MAX'(row  & field_mask(addr_w)) << row_lsb(packet_w, addr_w));
      p = p | (PKT_MAX'(col  & field_mask(addr_w)) << col_lsb(packet_w, addr_w));
      p = p | (PKT_MAX'(ch   & field_mask(ch_w))   << ch_lsb(packet_w, addr_w, ch_w));
      p = p | PKT_MAX'(psum & field_mask(psum_w));
      return p;
   endfunction

endpackage

// File: rtl/snn_pe_window_dot.sv
// Combinational masked adder: sums the weights whose spike bit is set in the window.
module snn_window_dot #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned FILT_LEN = 5,
   parameter int unsigned PSUM_W   = 13
) (
   input  logic [FILT_LEN*WIDTH-1:0] weights,
   input  logic [FILT_LEN-1:0]       window,
   output logic [PSUM_W-1:0]         psum_c
);

   always_comb begin
      psum_c = '0;
      for (int y = 0; y < int'(FILT_LEN); y++) begin
         if (window[y]) psum_c = psum_c + PSUM_W'(weights[y*WIDTH +: WIDTH]);
      end
   end

endmodule

// File: rtl/snn_conv_row_pe.sv
// Spike-row convolution PE: slides NUM_CH filter rows over one spike row and emits tagged psums.
module snn_conv_row_pe
   import snn_pe_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned FILT_LEN = 5,
   parameter int unsigned IFMAP_W  = 25,
   parameter int unsigned NUM_CH   = 1,
   parameter int unsigned PSUM_W   = 13,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned CH_W     = $clog2(NUM_CH > 1 ? NUM_CH : 2),
   parameter int unsigned PACKET_W = 40
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             filter_valid,
   output logic                             filter_ready,
   input  logic [NUM_CH*FILT_LEN*WIDTH-1:0] filter_data,
   input  logic                             ifmap_valid,
   output logic                             ifmap_ready,
   input  logic [IFMAP_W-1:0]               ifmap_data,
   output logic                             psum_valid,
   input  logic                             psum_ready,
   output logic [PACKET_W-1:0]              psum_data,
   output logic                             busy,
   output logic                             timestep_done
);

   localparam int unsigned COLS = IFMAP_W - FILT_LEN + 1;
   localparam int unsigned ROWS = COLS;
   localparam int unsigned FLW  = FILT_LEN * WIDTH;

   if (PSUM_W < WIDTH + $clog2(FILT_LEN + 1)) begin : g_bad_psum_w
      $error("PSUM_W too narrow for FILT_LEN weights");
   end
   if ((2 ** ADDR_W) < COLS) begin : g_bad_addr_w
      $error("ADDR_W too narrow for column count");
   end
   if (PACKET_W < 2 * ADDR_W + CH_W + PSUM_W) begin : g_bad_packet_w
      $error("PACKET_W too narrow for packet fields");
   end

   state_t                     state;
   logic [NUM_CH*FLW-1:0]      weights;
   logic [IFMAP_W-1:0]         spike_row;
   logic [ADDR_W-1:0]          row_cnt;
   logic [ADDR_W-1:0]          col_cnt;
   logic [CH_W-1:0]            ch_cnt;
   logic                       more;

   logic                       in_wait;
   logic [ADDR_W-1:0]          sel_col;
   logic [CH_W-1:0]            sel_ch;
   logic [IFMAP_W-1:0]         src_row;
   logic [FILT_LEN-1:0]        window;
   logic [FLW-1:0]             ch_weights;
   logic [PSUM_W-1:0]          dot;
   logic                       sel_last;
   logic [ADDR_W-1:0]          nxt_col;
   logic [CH_W-1:0]            nxt_ch;
   logic [PACKET_W-1:0]        packet;

   // Filter wins over a simultaneous spike row.
   assign ifmap_ready = (state == S_WAIT_ROW) && !filter_valid;

   // The first packet of a row is computed straight from ifmap_data so it appears one cycle after accept.
   always_comb begin
      in_wait    = (state == S_WAIT_ROW);
      sel_col    = in_wait ? '0 : col_cnt;
      sel_ch     = in_wait ? '0 : ch_cnt;
      src_row    = in_wait ? ifmap_data : spike_row;
      window     = FILT_LEN'(src_row >> sel_col);
      ch_weights = FLW'(weights >> (32'(sel_ch) * FLW));
      sel_last   = (sel_col == ADDR_W'(COLS - 1)) && (sel_ch == CH_W'(NUM_CH - 1));
      nxt_col    = sel_col;
      nxt_ch     = sel_ch + CH_W'(1);
      if (sel_ch == CH_W'(NUM_CH - 1)) begin
         nxt_ch  = '0;
         nxt_col = sel_col + ADDR_W'(1);
      end
      packet = PACKET_W'(pack_psum(32'(row_cnt), 32'(sel_col), 32'(sel_ch), 32'(dot),
                                   PACKET_W, ADDR_W, CH_W, PSUM_W));
   end

   snn_window_dot #(
      .WIDTH   (WIDTH),
      .FILT_LEN(FILT_LEN),
      .PSUM_W  (PSUM_W)
   ) u_dot (
      .weights(ch_weights),
      .window (window),
      .psum_c (dot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_NOFILT;
         filter_ready  <= 1'b0;
         psum_valid    <= 1'b0;
         busy          <= 1'b0;
         timestep_done <= 1'b0;
         psum_data     <= '0;
         row_cnt       <= '0;
         col_cnt       <= '0;
         ch_cnt        <= '0;
         weights       <= '0;
         spike_row     <= '0;
         more          <= 1'b0;
      end else begin
         timestep_done <= 1'b0;
         case (state)
            S_NOFILT: begin
               filter_ready <= 1'b1;
               if (filter_valid && filter_ready) begin
                  weights <= filter_data;
                  row_cnt <= '0;
                  state   <= S_WAIT_ROW;
               end
            end
            S_WAIT_ROW: begin
               filter_ready <= 1'b1;
               if (filter_valid && filter_ready) begin
                  weights <= filter_data;
                  row_cnt <= '0;
               end else if (ifmap_valid && ifmap_ready) begin
                  spike_row    <= ifmap_data;
                  psum_data    <= packet;
                  psum_valid   <= 1'b1;
                  col_cnt      <= nxt_col;
                  ch_cnt       <= nxt_ch;
                  more         <= !sel_last;
                  filter_ready <= 1'b0;
                  busy         <= 1'b1;
                  state        <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if ((!psum_valid || psum_ready) && more) begin
                  psum_data  <= packet;
                  psum_valid <= 1'b1;
                  col_cnt    <= nxt_col;
                  ch_cnt     <= nxt_ch;
                  more       <= !sel_last;
               end else if (psum_valid && psum_ready) begin
                  // Last packet of the row accepted.
                  psum_valid   <= 1'b0;
                  busy         <= 1'b0;
                  filter_ready <= 1'b1;
                  state        <= S_WAIT_ROW;
                  if (row_cnt == ADDR_W'(ROWS - 1)) begin
                     row_cnt       <= '0;
                     timestep_done <= 1'b1;
                  end else begin
                     row_cnt <= row_cnt + ADDR_W'(1);
                  end
               end
            end
            default: state <= S_NOFILT;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_conv_row_pe.sv
// Directed bench for snn_conv_row_pe: single-channel and two-channel instances.
module tb_snn_conv_row_pe;

   localparam logic [79:0] W_RAMP = 80'h00_0000_0000_0504_030201;
   localparam logic [79:0] W_2CH  = 80'hFFFF_FFFF_FF05_0403_0201;
   localparam logic [24:0] ONES   = 25'h1FF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel2;
   logic        f_valid, i_valid, p_ready;
   logic [79:0] fdata;
   logic [24:0] idata;

   logic        fr1, ir1, pv1, busy1, td1;
   logic [39:0] pd1;
   logic        fr2, ir2, pv2, busy2, td2;
   logic [39:0] pd2;

   logic        f_rdy, i_rdy, o_valid, o_busy, o_td;
   logic [39:0] o_data;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   snn_conv_row_pe u_dut1 (
      .clk          (clk),
      .reset        (reset),
      .filter_valid (f_valid && !sel2),
      .filter_ready (fr1),
      .filter_data  (fdata[39:0]),
      .ifmap_valid  (i_valid && !sel2),
      .ifmap_ready  (ir1),
      .ifmap_data   (idata),
      .psum_valid   (pv1),
      .psum_ready   (p_ready || sel2),
      .psum_data    (pd1),
      .busy         (busy1),
      .timestep_done(td1)
   );

   snn_conv_row_pe #(.NUM_CH(2)) u_dut2 (
      .clk          (clk),
      .reset        (reset),
      .filter_valid (f_valid && sel2),
      .filter_ready (fr2),
      .filter_data  (fdata),
      .ifmap_valid  (i_valid && sel2),
      .ifmap_ready  (ir2),
      .ifmap_data   (idata),
      .psum_valid   (pv2),
      .psum_ready   (p_ready || !sel2),
      .psum_data    (pd2),
      .busy         (busy2),
      .timestep_done(td2)
   );

   assign f_rdy   = sel2 ? fr2   : fr1;
   assign i_rdy   = sel2 ? ir2   : ir1;
   assign o_valid = sel2 ? pv2   : pv1;
   assign o_busy  = sel2 ? busy2 : busy1;
   assign o_td    = sel2 ? td2   : td1;
   assign o_data  = sel2 ? pd2   : pd1;

   typedef struct {
      logic [24:0] ifmap;
      int          pa;
      int          hot_col;
      int          hot_val;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [39:0] exp_pkt(input int row, input int col, input int ch, input int psum);
      return {5'(row), 5'(col), 1'(ch), 16'h0000, 13'(psum)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_filter(input logic [79:0] w);
      int n;
      fdata   = w;
      f_valid = 1'b1;
      n = 0;
      while (!f_rdy && n < 20) begin
         tick();
         n++;
      end
      chk("filter_accept", 64'(f_rdy), 64'd1);
      tick();
      f_valid = 1'b0;
   endtask

   task automatic send_row(input logic [24:0] d);
      int n;
      idata   = d;
      i_valid = 1'b1;
      #1;
      n = 0;
      while (!i_rdy && n < 20) begin
         tick();
         n++;
      end
      chk("ifmap_accept", 64'(i_rdy), 64'd1);
      tick();
      i_valid = 1'b0;
   endtask

   // Entered one cycle after the ifmap handshake; walks every packet of the row in order.
   task automatic collect(input string name, input int nch, input int row, input int pa, input int pb,
                          input int hot_col, input int hot_val, input int stall_col,
                          input int abort_col, output bit aborted);
      int k, cyc, stalls, npk, col, ch, psum, tdn;
      npk = 21 * nch;
      k = 0; cyc = 0; stalls = 0; tdn = 0;
      aborted = 1'b0;
      chk({name, "_latency"}, 64'(o_valid), 64'd1);
      chk({name, "_busy"}, 64'(o_busy), 64'd1);
      p_ready = 1'b1;
      while (k < npk && cyc < npk + 20) begin
         col  = k / nch;
         ch   = k % nch;
         psum = (ch != 0) ? pb : ((col == hot_col) ? hot_val : pa);
         if (o_td) tdn++;
         if (o_valid && col == abort_col) begin
            aborted = 1'b1;
            break;
         end
         if (o_valid) begin
            if (col == stall_col && stalls < 3) begin
               p_ready = 1'b0;
               stalls++;
               chk({name, "_hold"}, 64'(o_data), 64'(exp_pkt(row, col, ch, psum)));
            end else begin
               p_ready = 1'b1;
               chk({name, "_pkt"}, 64'(o_data), 64'(exp_pkt(row, col, ch, psum)));
               k++;
            end
         end
         tick();
         cyc++;
      end
      p_ready = 1'b1;
      if (aborted) return;
      chk({name, "_count"}, 64'(k), 64'(npk));
      chk({name, "_cycles"}, 64'(cyc), 64'(npk + stalls));
      chk({name, "_td_early"}, 64'(tdn), 64'd0);
      chk({name, "_valid_drop"}, 64'(o_valid), 64'd0);
      chk({name, "_busy_drop"}, 64'(o_busy), 64'd0);
      chk({name, "_td"}, 64'(o_td), 64'((row == 20) ? 1 : 0));
   endtask

   initial begin
      vec_t tbl[4];
      bit   ab;

      tbl[0] = '{ONES,          15, -1, 0};
      tbl[1] = '{25'h000_0001,   0,  0, 1};
      tbl[2] = '{25'h100_0000,   0, 20, 5};
      tbl[3] = '{25'h000_0000,   0, -1, 0};

      reset = 1'b1; sel2 = 1'b0; f_valid = 1'b0; i_valid = 1'b0; p_ready = 1'b1;
      fdata = '0; idata = '0;
      tick();
      tick();
      chk("rst_psum_valid", 64'(o_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_filter_ready", 64'(f_rdy), 64'd0);
      chk("rst_ifmap_ready", 64'(i_rdy), 64'd0);
      chk("rst_psum_data", 64'(o_data), 64'd0);
      chk("rst_td", 64'(o_td), 64'd0);
      reset = 1'b0;
      tick();
      chk("nofilt_filter_ready", 64'(f_rdy), 64'd1);
      chk("nofilt_ifmap_ready", 64'(i_rdy), 64'd0);

      load_filter(W_RAMP);
      for (int i = 0; i < 4; i++) begin
         send_row(tbl[i].ifmap);
         collect($sformatf("row%0d", i), 1, i, tbl[i].pa, 0, tbl[i].hot_col, tbl[i].hot_val,
                 -1, -1, ab);
      end

      // Filter and row presented together: filter must win, then the row is tagged 0.
      fdata = W_RAMP; f_valid = 1'b1; idata = ONES; i_valid = 1'b1;
      #1;
      chk("prio_ifmap_ready", 64'(i_rdy), 64'd0);
      chk("prio_filter_ready", 64'(f_rdy), 64'd1);
      tick();
      f_valid = 1'b0;
      #1;
      chk("prio_ifmap_ready_after", 64'(i_rdy), 64'd1);
      tick();
      i_valid = 1'b0;
      collect("bp", 1, 0, 15, 0, -1, 0, 4, -1, ab);

      for (int r = 1; r < 21; r++) begin
         send_row(ONES);
         collect($sformatf("ts%0d", r), 1, r, 15, 0, -1, 0, -1, -1, ab);
      end
      tick();
      chk("td_pulse_width", 64'(o_td), 64'd0);

      // Row after the wrap is tagged 0; reset it partway through.
      send_row(ONES);
      collect("wrap", 1, 0, 15, 0, -1, 0, -1, 10, ab);
      chk("abort_reached", 64'(ab), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_psum_valid", 64'(o_valid), 64'd0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_ifmap_ready", 64'(i_rdy), 64'd0);
      tick();
      chk("abort_filter_ready", 64'(f_rdy), 64'd1);
      idata = ONES; i_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("nofilt_block_ifmap", 64'(i_rdy), 64'd0);
         chk("nofilt_no_psum", 64'(o_valid), 64'd0);
         tick();
      end
      i_valid = 1'b0;
      load_filter(W_RAMP);
      send_row(ONES);
      collect("reload", 1, 0, 15, 0, -1, 0, -1, -1, ab);

      sel2 = 1'b1;
      load_filter(W_2CH);
      send_row(ONES);
      collect("two_ch", 2, 0, 15, 1275, -1, 0, -1, -1, ab);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/snn_conv_row_pe.md
Name: snn_conv_row_pe

Overview:
Clocked, parametrised successor to the spike-row convolution PE used in the SNN conv array.
- Holds NUM_CH filter rows of FILT_LEN weights each.
- Accepts one binary spike row (IFMAP_W bits) per transaction.
- Slides each filter across the row and emits one tagged psum packet per (column, channel).
- Sits between the filter/ifmap distribution network and the psum adder/accumulation stage.
- Adds multi-channel filters, filter reload, output backpressure and a timestep-done strobe.

Parameters:
WIDTH, 8, weight width in bits
FILT_LEN, 5, filter taps per row
IFMAP_W, 25, spike-row width in bits
NUM_CH, 1, number of filter channels held concurrently
PSUM_W, 13, psum field width; must be >= WIDTH+$clog2(FILT_LEN+1) (elaboration assert)
ADDR_W, 5, row/column tag width; must satisfy 2**ADDR_W >= IFMAP_W-FILT_LEN+1
CH_W, $clog2(NUM_CH>1?NUM_CH:2), channel tag width
PACKET_W, 40, output packet width; must be >= 2*ADDR_W+CH_W+PSUM_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
filter_valid  in  1  filter packet valid
filter_ready  out  1  filter packet accepted when valid&&ready
filter_data  in  NUM_CH*FILT_LEN*WIDTH  weight w[c][y] = filter_data[(c*FILT_LEN+y)*WIDTH +: WIDTH]
ifmap_valid  in  1  spike row valid
ifmap_ready  out  1  spike row accepted when valid&&ready
ifmap_data  in  IFMAP_W  spike bit i = ifmap_data[i]
psum_valid  out  1  output packet valid
psum_ready  in  1  downstream accept
psum_data  out  PACKET_W  {row[ADDR_W], col[ADDR_W], ch[CH_W], zero pad, psum[PSUM_W]}, MSB first
busy  out  1  high in S_COMPUTE
timestep_done  out  1  one-cycle pulse when the last row of a timestep completes

Behaviour:
- Constants: COLS = IFMAP_W-FILT_LEN+1; ROWS = COLS.
- Reset: the following are all cleared to 0:
  - FSM -> S_NOFILT
  - filter_ready, ifmap_ready, psum_valid, busy, timestep_done
  - psum_data, row_cnt, col_cnt, ch_cnt
  - filter storage
- Reset mid-compute aborts the row; pending packets are discarded and a filter reload is required.
- S_NOFILT:
  - filter_ready=1, ifmap_ready=0.
  - On filter handshake: latch weights, row_cnt=0, go to S_WAIT_ROW.
- S_WAIT_ROW:
  - filter_ready=1, ifmap_ready=!filter_valid (filter has priority on simultaneous valid).
  - On filter handshake: reload weights, row_cnt=0, stay in S_WAIT_ROW.
  - On ifmap handshake: latch row, col_cnt=0, ch_cnt=0, go to S_COMPUTE.
- S_COMPUTE:
  - filter_ready=0, ifmap_ready=0.
  - Packet order is column-major, channel-minor: (col0,ch0), (col0,ch1), …, (COLS-1, NUM_CH-1).
- Arithmetic:
  - psum[c][x] = sum over y<FILT_LEN of (spike[x+y] ? w[c][y] : 0), unsigned, zero-extended to PSUM_W.
  - No truncation is possible given the PSUM_W constraint.
- Output register:
  - Loads the next packet when (!psum_valid || psum_ready) and packets remain.
  - psum_valid and psum_data are held stable while psum_valid && !psum_ready.
  - Latency: ifmap handshake at cycle T -> first psum_valid at T+1.
  - Throughput: 1 packet/cycle with psum_ready held high.
- Row completion:
  - When the last packet is accepted, go to S_WAIT_ROW in the same cycle (psum_valid drops the next cycle).
  - If row_cnt==ROWS-1: row_cnt wraps to 0 and timestep_done pulses for 1 cycle. Otherwise row_cnt++.
- Tags: row = row_cnt, col = col_cnt, ch = ch_cnt; zero pad bits are always 0.
- Debug $display calls are forbidden in synthesizable RTL.

Decomposition:
- Package snn_pe_pkg holds:
  - state enum (S_NOFILT, S_WAIT_ROW, S_COMPUTE)
  - packet field offset localparams
  - function pack_psum(row, col, ch, psum)
- Sub-module snn_window_dot: combinational FILT_LEN-tap masked adder (weights, spike window -> psum), instantiated once and muxed by col_cnt/ch_cnt.

Test Plan:
- Weights 1,2,3,4,5, ifmap all ones, psum_ready=1 -> 21 packets on consecutive cycles; col 0..20, row 0, psum 15 each; first valid 1 cycle after accept.
- Same weights, ifmap=bit0 only -> col0 psum 1, cols 1..20 psum 0. Ifmap=bit24 only -> col20 psum 5, all others 0.
- psum_ready low for 3 cycles while packet col=4 is valid -> data held unchanged; col=5 follows the next accepted cycle; no packet lost or duplicated.
- 21 rows back to back -> row tags 0..20, timestep_done single pulse after the 21st row's last packet, 22nd row tagged row 0. Filter reload between rows 3 and 4 -> next row tagged 0.
- NUM_CH=2, ch0 weights 1..5, ch1 all 255, ifmap all ones -> alternating ch0 psum 15 / ch1 psum 1275, 42 packets.
- Assert reset during col=10 -> next cycle psum_valid=0, busy=0, filter_ready=1, ifmap_ready=0; ifmap not accepted until a filter is reloaded.
